// File: rtl/defs_pkg.sv
// Shared types and constants for the two-requester AXI read arbiter.
package defs_pkg;

    localparam int AxiIdWidth = 4;

    // Requester indices.
    localparam logic REQ_IFU = 1'b0;
    localparam logic REQ_LSU = 1'b1;

    // Fixed AXI attributes for every AR issued.
    localparam logic [2:0] AXI_SIZE_8B    = 3'b011;
    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ADDR  = 2'd1,
        ST_DATA  = 2'd2,
        ST_DRAIN = 2'd3
    } arb_state_e;

endpackage

// File: rtl/axi_rd_arb_if.sv
// Requester-side and fabric-side signals of the read arbiter, bundled.
interface axi_rd_arb_if;
    import defs_pkg::*;

    logic [1:0]            req_arvalid;
    logic [1:0]            req_arready;
    logic [63:0]           req_araddr;
    logic [15:0]           req_arlen;
    logic [1:0]            req_abort;
    logic [1:0]            req_rvalid;
    logic [1:0]            req_rready;
    logic [63:0]           req_rdata;
    logic [1:0]            req_rresp;
    logic                  req_rlast;

    logic [AxiIdWidth-1:0] m_arid;
    logic [31:0]           m_araddr;
    logic [7:0]            m_arlen;
    logic [2:0]            m_arsize;
    logic [1:0]            m_arburst;
    logic                  m_arvalid;
    logic                  m_arready;
    logic [AxiIdWidth-1:0] m_rid;
    logic [63:0]           m_rdata;
    logic [1:0]            m_rresp;
    logic                  m_rlast;
    logic                  m_rvalid;
    logic                  m_rready;

    // Arbiter view.
    modport master (
        input  req_arvalid, req_araddr, req_arlen, req_abort, req_rready,
               m_arready, m_rid, m_rdata, m_rresp, m_rlast, m_rvalid,
        output req_arready, req_rvalid, req_rdata, req_rresp, req_rlast,
               m_arid, m_araddr, m_arlen, m_arsize, m_arburst, m_arvalid, m_rready
    );

    // Environment view (requesters plus fabric).
    modport slave (
        output req_arvalid, req_araddr, req_arlen, req_abort, req_rready,
               m_arready, m_rid, m_rdata, m_rresp, m_rlast, m_rvalid,
        input  req_arready, req_rvalid, req_rdata, req_rresp, req_rlast,
               m_arid, m_araddr, m_arlen, m_arsize, m_arburst, m_arvalid, m_rready
    );
endinterface

// File: rtl/rr_arb2.sv
// Two-way round-robin grant; on contention the index opposite the last grant wins.
module rr_arb2
    import defs_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req_i,
    input  logic       update_i,
    output logic [1:0] gnt_o,
    output logic       idx_o
);

    logic pref_q, pref_d;

    // Select the winner and compute the preference for the next contention.
    always_comb begin
        idx_o  = REQ_IFU;
        gnt_o  = 2'b00;
        pref_d = pref_q;
        if (req_i == 2'b11) begin
            idx_o = pref_q;
        end else if (req_i[REQ_LSU]) begin
            idx_o = REQ_LSU;
        end
        if (req_i != 2'b00) begin
            gnt_o[idx_o] = 1'b1;
            if (update_i) begin
                pref_d = ~idx_o;
            end
        end
    end

    // Preference register, index 0 favoured out of reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pref_q <= REQ_IFU;
        end else begin
            pref_q <= pref_d;
        end
    end

endmodule

// File: rtl/axi_rd_arb.sv
// AXI read arbiter: two requesters share one fabric read port, one burst at a time.
//
//   state    | meaning
//   ---------+-------------------------------------------------------------
//   ST_IDLE  | no burst; grant a requester and latch its AR fields
//   ST_ADDR  | AR presented to fabric until accepted; owner abort is recorded
//   ST_DATA  | beats routed to owner; owner abort switches to drain at once
//   ST_DRAIN | beats swallowed (m_rready=1) until the last one
module axi_rd_arb
    import defs_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    axi_rd_arb_if.master bus
);

    arb_state_e  state_q, state_d;
    logic        owner_q, owner_d;
    logic [31:0] addr_q, addr_d;
    logic [7:0]  len_q, len_d;
    logic        abort_q, abort_d;

    logic [1:0]  gnt;
    logic        gnt_idx;
    logic        grant_en;
    logic        own_abort;
    logic        own_rready;

    assign own_abort  = bus.req_abort[owner_q];
    assign own_rready = bus.req_rready[owner_q];

    rr_arb2 u_rr (
        .clk      (clk),
        .rst      (rst),
        .req_i    (bus.req_arvalid),
        .update_i (grant_en),
        .gnt_o    (gnt),
        .idx_o    (gnt_idx)
    );

    // Next-state and handshake outputs.
    always_comb begin
        state_d         = state_q;
        owner_d         = owner_q;
        addr_d          = addr_q;
        len_d           = len_q;
        abort_d         = abort_q;
        grant_en        = 1'b0;
        bus.req_arready = 2'b00;
        bus.req_rvalid  = 2'b00;
        bus.m_arvalid   = 1'b0;
        bus.m_rready    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                abort_d = 1'b0;
                // Reset is checked here so no grant pulse escapes while rst is high.
                if (!rst && bus.req_arvalid != 2'b00) begin
                    grant_en        = 1'b1;
                    bus.req_arready = gnt;
                    owner_d         = gnt_idx;
                    addr_d          = gnt_idx ? bus.req_araddr[63:32] : bus.req_araddr[31:0];
                    len_d           = gnt_idx ? bus.req_arlen[15:8] : bus.req_arlen[7:0];
                    state_d         = ST_ADDR;
                end
            end
            ST_ADDR: begin
                bus.m_arvalid = 1'b1;
                if (own_abort) begin
                    abort_d = 1'b1;
                end
                if (bus.m_arready) begin
                    state_d = (abort_q || own_abort) ? ST_DRAIN : ST_DATA;
                end
            end
            ST_DATA: begin
                if (own_abort) begin
                    bus.m_rready = 1'b1;
                    state_d      = (bus.m_rvalid && bus.m_rlast) ? ST_IDLE : ST_DRAIN;
                end else begin
                    bus.req_rvalid[owner_q] = bus.m_rvalid;
                    bus.m_rready            = own_rready;
                    if (bus.m_rvalid && own_rready && bus.m_rlast) begin
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_DRAIN: begin
                bus.m_rready = 1'b1;
                if (bus.m_rvalid && bus.m_rlast) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and latched AR fields.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            owner_q <= REQ_IFU;
            addr_q  <= '0;
            len_q   <= '0;
            abort_q <= 1'b0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            addr_q  <= addr_d;
            len_q   <= len_d;
            abort_q <= abort_d;
        end
    end

    assign bus.m_arid    = {{(AxiIdWidth-1){1'b0}}, owner_q};
    assign bus.m_araddr  = addr_q;
    assign bus.m_arlen   = len_q;
    assign bus.m_arsize  = AXI_SIZE_8B;
    assign bus.m_arburst = AXI_BURST_INCR;
    assign bus.req_rdata = bus.m_rdata;
    assign bus.req_rresp = bus.m_rresp;
    assign bus.req_rlast = bus.m_rlast;

    // Fabric must return the ID we issued; routing never depends on m_rid.
    a_rid_match: assert property (@(posedge clk) disable iff (rst)
        ((state_q == ST_DATA || state_q == ST_DRAIN) && bus.m_rvalid) |-> (bus.m_rid == bus.m_arid));

endmodule

// File: tb/tb_axi_rd_arb.sv
// Randomized bench with transaction-level reference model and scoreboard monitor.
module tb_axi_rd_arb;
    import defs_pkg::*;

    typedef struct {
        int          id;
        logic [31:0] addr;
        logic [7:0]  len;
    } ar_t;

    typedef struct {
        int          idx;
        logic [63:0] data;
        logic [1:0]  resp;
        logic        last;
    } beat_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    axi_rd_arb_if bus ();
    axi_rd_arb dut (.clk(clk), .rst(rst), .bus(bus));

    int    n_chk  = 0;
    int    n_fail = 0;
    int    pref   = 0;
    ar_t   ar_q[$];
    beat_t beat_q[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [1:0] oh(input int i);
        return (i == 1) ? 2'b10 : 2'b01;
    endfunction

    // Scoreboard monitor: compares every AR and every delivered beat.
    always @(negedge clk) begin
        ar_t   ea;
        beat_t eb;
        #2;
        if (!rst) begin
            if (bus.m_arvalid && bus.m_arready) begin
                if (ar_q.size() == 0) begin
                    chk("ar_unexpected", 64'(bus.m_araddr), 64'hDEAD_BEEF_0000);
                end else begin
                    ea = ar_q.pop_front();
                    chk("ar_id", 64'(bus.m_arid), 64'(ea.id));
                    chk("ar_addr", 64'(bus.m_araddr), 64'(ea.addr));
                    chk("ar_len", 64'(bus.m_arlen), 64'(ea.len));
                    chk("ar_size", 64'(bus.m_arsize), 64'(3'b011));
                    chk("ar_burst", 64'(bus.m_arburst), 64'(2'b01));
                end
            end
            for (int i = 0; i < 2; i++) begin
                if (bus.req_rvalid[i] && bus.req_rready[i]) begin
                    if (beat_q.size() == 0) begin
                        chk("beat_unexpected", 64'(i), 64'hDEAD_BEEF_0001);
                    end else begin
                        eb = beat_q.pop_front();
                        chk("beat_idx", 64'(i), 64'(eb.idx));
                        chk("beat_data", bus.req_rdata, eb.data);
                        chk("beat_resp", 64'(bus.req_rresp), 64'(eb.resp));
                        chk("beat_last", 64'(bus.req_rlast), 64'(eb.last));
                    end
                end
            end
        end
    end

    task automatic clear_inputs();
        bus.req_arvalid = 2'b00;
        bus.req_araddr  = '0;
        bus.req_arlen   = '0;
        bus.req_abort   = 2'b00;
        bus.req_rready  = 2'b00;
        bus.m_arready   = 1'b0;
        bus.m_rid       = '0;
        bus.m_rdata     = '0;
        bus.m_rresp     = '0;
        bus.m_rlast     = 1'b0;
        bus.m_rvalid    = 1'b0;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_arready"}, 64'(bus.req_arready), 64'd0);
        chk({tag, "_rvalid"}, 64'(bus.req_rvalid), 64'd0);
        chk({tag, "_m_arvalid"}, 64'(bus.m_arvalid), 64'd0);
        chk({tag, "_m_rready"}, 64'(bus.m_rready), 64'd0);
        chk({tag, "_m_arid"}, 64'(bus.m_arid), 64'd0);
        chk({tag, "_m_araddr"}, 64'(bus.m_araddr), 64'd0);
        chk({tag, "_m_arlen"}, 64'(bus.m_arlen), 64'd0);
    endtask

    // One burst from grant to last beat. Called at a negedge with the DUT idle.
    // amode: 0 none, 1 owner abort during AR, 2 owner abort during data.
    task automatic do_tx(input logic [1:0] mask, input logic [31:0] a0, input logic [31:0] a1,
                         input logic [7:0] l0, input logic [7:0] l1, input int ar_dly,
                         input int amode, input int abort_at, input int stall_at, input int rst_beat);
        int          w, nb, beat, stall_left, ab_pt;
        logic [31:0] wa;
        logic [7:0]  wl;
        bit          aborted, ab_now, stalled, rr, accept;
        ar_t         ea;
        beat_t       eb;

        w    = (mask == 2'b11) ? pref : (mask[1] ? 1 : 0);
        pref = 1 - w;
        wa   = (w == 1) ? a1 : a0;
        wl   = (w == 1) ? l1 : l0;

        bus.req_arvalid = mask;
        bus.req_araddr  = {a1, a0};
        bus.req_arlen   = {l1, l0};
        bus.req_abort   = 2'($urandom_range(0, 3));
        ea.id = w; ea.addr = wa; ea.len = wl;
        ar_q.push_back(ea);
        #1;
        chk("grant", 64'(bus.req_arready), 64'(oh(w)));
        chk("idle_arvalid", 64'(bus.m_arvalid), 64'd0);
        @(negedge clk);

        // Address phase; other requesters keep random requests pending.
        ab_pt = abort_at % (ar_dly + 1);
        for (int c = 0; c <= ar_dly; c++) begin
            bus.req_arvalid = 2'($urandom_range(0, 3));
            bus.req_araddr  = {$urandom, $urandom};
            bus.m_arready   = (c == ar_dly);
            bus.req_abort   = 2'b00;
            if (amode == 1 && c == ab_pt) bus.req_abort[w] = 1'b1;
            else if ($urandom_range(0, 2) == 0) bus.req_abort[1 - w] = 1'b1;
            #1;
            chk("addr_arvalid", 64'(bus.m_arvalid), 64'd1);
            chk("addr_araddr_stable", 64'(bus.m_araddr), 64'(wa));
            chk("addr_no_grant", 64'(bus.req_arready), 64'd0);
            @(negedge clk);
        end
        bus.m_arready = 1'b0;

        aborted    = (amode == 1);
        nb         = int'(wl) + 1;
        beat       = 0;
        stall_left = 0;
        stalled    = 0;
        ab_pt      = abort_at % nb;
        while (beat < nb) begin
            bus.req_arvalid = 2'($urandom_range(0, 3));
            bus.req_abort   = 2'b00;
            bus.m_rvalid    = ($urandom_range(0, 3) != 0);
            bus.m_rid       = AxiIdWidth'(w);
            bus.m_rdata     = {$urandom, $urandom};
            bus.m_rresp     = 2'($urandom_range(0, 3));
            bus.m_rlast     = (beat == nb - 1);
            rr = ($urandom_range(0, 3) != 0);
            if (stall_at == beat && !stalled) begin
                stalled    = 1;
                stall_left = 2;
            end
            if (stall_left > 0) begin
                rr = 0;
                bus.m_rvalid = 1'b1;
                stall_left--;
            end
            bus.req_rready    = 2'($urandom_range(0, 3));
            bus.req_rready[w] = rr;
            ab_now = 0;
            if (amode == 2 && !aborted && beat == ab_pt) begin
                bus.req_abort[w] = 1'b1;
                ab_now = 1;
            end else if ($urandom_range(0, 2) == 0) begin
                bus.req_abort[1 - w] = 1'b1;
            end

            if (beat == rst_beat) begin
                // Reset lands on a live beat; the whole burst is forgotten.
                bus.m_rvalid    = 1'b1;
                bus.req_arvalid = 2'b11;
                rst = 1'b1;
                #1;
                chk_reset_outputs("rst_mid");
                @(negedge clk);
                rst = 1'b0;
                clear_inputs();
                pref = 0;
                return;
            end

            accept = bus.m_rvalid && (aborted || ab_now || rr);
            if (accept && !(aborted || ab_now)) begin
                eb.idx = w; eb.data = bus.m_rdata; eb.resp = bus.m_rresp; eb.last = bus.m_rlast;
                beat_q.push_back(eb);
            end
            #1;
            chk("data_m_rready", 64'(bus.m_rready), (aborted || ab_now) ? 64'd1 : 64'(rr));
            chk("data_rvalid_route", 64'(bus.req_rvalid),
                (aborted || ab_now || !bus.m_rvalid) ? 64'd0 : 64'(oh(w)));
            chk("data_no_grant", 64'(bus.req_arready), 64'd0);
            if (ab_now) aborted = 1;
            if (accept) beat++;
            @(negedge clk);
        end
        clear_inputs();
    endtask

    task automatic idle_gap(input int n);
        for (int i = 0; i < n; i++) begin
            clear_inputs();
            #1;
            chk("gap_arvalid", 64'(bus.m_arvalid), 64'd0);
            chk("gap_rvalid", 64'(bus.req_rvalid), 64'd0);
            chk("gap_no_grant", 64'(bus.req_arready), 64'd0);
            @(negedge clk);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        clear_inputs();
        rst = 1'b1;
        bus.req_arvalid = 2'b11;
        #1;
        chk_reset_outputs("rst_init");
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        clear_inputs();

        // Contention twice after reset: 0 then 1.
        do_tx(2'b11, 32'h0000_0100, 32'h0000_0200, 8'd1, 8'd2, 0, 0, 0, -1, -1);
        do_tx(2'b11, 32'h0000_0300, 32'h0000_0400, 8'd0, 8'd1, 1, 0, 0, -1, -1);
        // Requester 0, 4 beats, AR accepted after 3 wait cycles.
        do_tx(2'b01, 32'h0000_1000, 32'h0000_2000, 8'd3, 8'd5, 3, 0, 0, -1, -1);
        // Requester 1 stalls rready two cycles mid-burst.
        do_tx(2'b10, 32'h0000_3000, 32'h0000_4000, 8'd2, 8'd4, 0, 0, 0, 2, -1);
        // Abort during AR, 8 beats drained.
        do_tx(2'b01, 32'h0000_5000, 32'h0000_6000, 8'd7, 8'd1, 2, 1, 1, -1, -1);
        do_tx(2'b10, 32'h0000_7000, 32'h0000_8000, 8'd0, 8'd2, 0, 0, 0, -1, -1);
        // Reset on beat 2, then contention must favour index 0 again.
        do_tx(2'b10, 32'h0000_9000, 32'h0000_A000, 8'd1, 8'd5, 1, 0, 0, -1, 2);
        do_tx(2'b11, 32'h0000_B000, 32'h0000_C000, 8'd2, 8'd3, 0, 0, 0, -1, -1);

        for (int t = 0; t < 60; t++) begin
            int r, am;
            r  = $urandom_range(0, 5);
            am = (r == 0) ? 1 : ((r == 1) ? 2 : 0);
            do_tx(2'($urandom_range(1, 3)), $urandom & 32'hFFFF_FFF8, $urandom & 32'hFFFF_FFF8,
                  8'($urandom_range(0, 7)), 8'($urandom_range(0, 7)), $urandom_range(0, 3),
                  am, $urandom_range(0, 7),
                  ($urandom_range(0, 3) == 0) ? $urandom_range(0, 3) : -1, -1);
            if ($urandom_range(0, 2) == 0) idle_gap($urandom_range(1, 2));
        end

        idle_gap(3);
        chk("ar_queue_empty", 64'(ar_q.size()), 64'd0);
        chk("beat_queue_empty", 64'(beat_q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/axi_rd_arb.md
AXI_RD_ARB -- requirements
Module: axi_rd_arb

Interface
REQ-001 Parameters: none; AxiIdWidth comes from defs_pkg; requester count fixed at 2 (index 0 = IFU fetch, index 1 = LSU load).
REQ-002 clk  in  1  sole clock, all state on rising edge.
REQ-003 rst  in  1  asynchronous, active-high reset.
REQ-004 req_arvalid  in  2  per-requester read-burst request.
REQ-005 req_arready  out  2  per-requester request accepted (grant pulse).
REQ-006 req_araddr  in  64  two packed 32-bit byte addresses, [31:0] = requester 0.
REQ-007 req_arlen  in  16  two packed 8-bit AXI burst lengths (beats-1).
REQ-008 req_abort  in  2  owner discards the rest of its burst (e.g. IFU flush).
REQ-009 req_rvalid  out  2  data beat valid to the owning requester only.
REQ-010 req_rready  in  2  requester accepts beat.
REQ-011 req_rdata  out  64  broadcast beat data (m_rdata).
REQ-012 req_rresp  out  2  broadcast beat response (m_rresp).
REQ-013 req_rlast  out  1  broadcast last-beat flag (m_rlast).
REQ-014 m_arid  out  AxiIdWidth  owner index, zero-extended.
REQ-015 m_araddr  out  32  latched owner address.
REQ-016 m_arlen  out  8  latched owner length.
REQ-017 m_arsize  out  3  constant 3'b011 (8 bytes).
REQ-018 m_arburst  out  2  constant 2'b01 (INCR).
REQ-019 m_arvalid  out  1  AR request to fabric.
REQ-020 m_arready  in  1  fabric accepts AR.
REQ-021 m_rid  in  AxiIdWidth  returned ID.
REQ-022 m_rdata  in  64  returned data.
REQ-023 m_rresp  in  2  returned response.
REQ-024 m_rlast  in  1  last beat.
REQ-025 m_rvalid  in  1  beat valid.
REQ-026 m_rready  out  1  beat accepted.

Function
REQ-027 FSM states IDLE, ADDR, DATA, DRAIN; exactly one burst outstanding at any time.
REQ-028 IDLE: if any req_arvalid, grant one requester, pulse its req_arready for that cycle, latch index/addr/len, go to ADDR; both requesting -> grant the index opposite the last-granted one (round-robin, initial preference = 0).
REQ-029 Grant latency: request seen in IDLE cycle N -> m_arvalid high from cycle N+1.
REQ-030 ADDR: m_arvalid=1 with m_arid/m_araddr/m_arlen stable until m_arready; on handshake go to DATA, or to DRAIN if abort is pending.
REQ-031 DATA: req_rvalid[owner]=m_rvalid, m_rready=req_rready[owner], other req_rvalid bit 0; handshake with m_rlast -> IDLE.
REQ-032 req_abort[owner] in ADDR -> set abort-pending; AR is never retracted.
REQ-033 req_abort[owner] in DATA -> DRAIN starting the same cycle: req_rvalid forced 0, m_rready=1.
REQ-034 DRAIN: m_rready=1, no req_rvalid; m_rlast handshake -> IDLE.
REQ-035 req_abort from a non-owner, or asserted in IDLE, is ignored.
REQ-036 After the last beat, the next grant comes no earlier than the following IDLE cycle (minimum 1 idle cycle between bursts).
REQ-037 m_rid must equal the latched owner index; a mismatch fires an assertion, and routing uses the latched owner regardless.
REQ-038 Beats with m_rresp != OKAY are forwarded unchanged; the arbiter takes no error action.

Reset
REQ-039 rst high at any time, including mid-burst: state IDLE, round-robin preference 0, abort-pending 0, req_arready=0, req_rvalid=0, m_arvalid=0, m_rready=0, latched index/addr/len=0; outstanding fabric beats are not tracked after reset.

Structure
REQ-040 The FSM state enum, the requester-index constants, and the AXI size/burst/resp constants live in defs_pkg; one sub-module, rr_arb2 (2-way round-robin grant with a priority register), is instantiated.

Verification
REQ-041 Both requesters assert in the same cycle after reset -> req_arready=2'b01, m_arid=0; second contention -> 2'b10.
REQ-042 Requester 0, addr 0x1000, len 3; fabric returns 4 beats with m_arready delayed 3 cycles -> m_araddr stays stable; exactly 4 req_rvalid[0] beats; IDLE after rlast.
REQ-043 req_rready[1] low for 2 cycles mid-burst -> m_rready low for the same cycles; no beat lost or duplicated.
REQ-044 req_abort[0] during ADDR, len 7 -> AR completes; 8 beats drained with req_rvalid=0; next grant served normally.
REQ-045 rst pulsed during DATA beat 2 -> all outputs at reset values in the same cycle; new request granted after rst deasserts.
